// File: rtl/cve2_pkg.sv
// Shared types for the FP writeback stage.
// Status bit order matches the fflags CSR layout.
package cve2_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  waddr;
    logic        dst_int;
    status_t     status;
  } fp_wb_entry_t;

endpackage

// File: rtl/cve2_fp_wb_fifo.sv
// In-order result FIFO for FP writeback.
// Also exposes every slot and its valid bit for hazard queries.
module cve2_fp_wb_fifo
  import cve2_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  fp_wb_entry_t              wdata_i,
  output fp_wb_entry_t              head_o,
  output logic                      full_o,
  output logic                      empty_o,
  output fp_wb_entry_t [Depth-1:0]  entries_o,
  output logic [Depth-1:0]          valid_o
);

  localparam int AW = $clog2(Depth);

  logic [AW-1:0]             wptr_q;
  logic [AW-1:0]             rptr_q;
  logic [AW:0]               cnt_q;
  fp_wb_entry_t [Depth-1:0]  mem_q;
  logic                      do_push;
  logic                      do_pop;
  logic [AW-1:0]             off;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o    = mem_q[rptr_q];
  assign entries_o = mem_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = '0;
    off     = '0;
    for (int i = 0; i < Depth; i++) begin
      off        = AW'(i) - rptr_q;
      valid_o[i] = ({1'b0, off} < cnt_q);
    end
  end

endmodule

// File: rtl/cve2_fp_wb_stage.sv
// FP result writeback buffer: FIFO, RF port arbitration,
// sticky fflags and destination-pending queries.
module cve2_fp_wb_stage
  import cve2_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fpu_out_valid_i,
  output logic        fpu_out_ready_o,
  input  logic [31:0] fpu_result_i,
  input  logic [4:0]  fpu_status_i,
  input  logic [4:0]  fpu_waddr_i,
  input  logic        fpu_dst_int_i,
  input  logic        int_wb_req_i,
  input  logic        flush_i,
  output logic        rf_int_we_o,
  output logic        rf_fp_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  input  logic        fflags_we_i,
  input  logic [4:0]  fflags_wdata_i,
  output logic [4:0]  fflags_o,
  input  logic [4:0]  query_addr_i,
  input  logic        query_fp_i,
  output logic        query_hit_o,
  output logic        busy_o
);

  fp_wb_entry_t              wentry;
  fp_wb_entry_t              head;
  fp_wb_entry_t [Depth-1:0]  entries;
  logic [Depth-1:0]          valid;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic [4:0]                fflags_q;
  logic [4:0]                fflags_d;

  assign wentry.data    = fpu_result_i;
  assign wentry.waddr   = fpu_waddr_i;
  assign wentry.dst_int = fpu_dst_int_i;
  assign wentry.status  = status_t'(fpu_status_i);

  assign fpu_out_ready_o = ~full;
  assign busy_o          = ~empty;
  assign push = fpu_out_valid_i & ~full & ~flush_i;
  assign pop  = ~empty & ~int_wb_req_i & ~flush_i;

  cve2_fp_wb_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (push),
    .pop_i     (pop),
    .flush_i   (flush_i),
    .wdata_i   (wentry),
    .head_o    (head),
    .full_o    (full),
    .empty_o   (empty),
    .entries_o (entries),
    .valid_o   (valid)
  );

  // x0 results still retire, they just never write.
  assign rf_int_we_o = pop & head.dst_int & (head.waddr != 5'd0);
  assign rf_fp_we_o  = pop & ~head.dst_int;
  assign rf_waddr_o  = pop ? head.waddr : 5'd0;
  assign rf_wdata_o  = pop ? head.data : 32'd0;

  always_comb begin
    fflags_d = fflags_we_i ? fflags_wdata_i : fflags_q;
    if (pop) begin
      fflags_d = fflags_d | head.status;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags_o = fflags_q;

  always_comb begin
    query_hit_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (valid[i] &&
          entries[i].waddr == query_addr_i &&
          entries[i].dst_int == ~query_fp_i) begin
        query_hit_o = 1'b1;
      end
    end
    if (!query_fp_i && query_addr_i == 5'd0) begin
      query_hit_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_cve2_fp_wb_stage.sv
// Directed bench for cve2_fp_wb_stage with a queue
// scoreboard of expected retirements.
module tb_cve2_fp_wb_stage;
  import cve2_pkg::*;

  localparam int Depth = 2;

  logic        clk;
  logic        rst_n;
  logic        fpu_valid;
  logic        fpu_ready;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_status;
  logic [4:0]  fpu_waddr;
  logic        fpu_dst_int;
  logic        int_wb_req;
  logic        flush;
  logic        rf_int_we;
  logic        rf_fp_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ff_we;
  logic [4:0]  ff_wdata;
  logic [4:0]  fflags;
  logic [4:0]  q_addr;
  logic        q_fp;
  logic        q_hit;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  fp_wb_entry_t sb[$];
  logic [4:0]   mff;

  cve2_fp_wb_stage #(.Depth(Depth)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .fpu_out_valid_i (fpu_valid),
    .fpu_out_ready_o (fpu_ready),
    .fpu_result_i    (fpu_result),
    .fpu_status_i    (fpu_status),
    .fpu_waddr_i     (fpu_waddr),
    .fpu_dst_int_i   (fpu_dst_int),
    .int_wb_req_i    (int_wb_req),
    .flush_i         (flush),
    .rf_int_we_o     (rf_int_we),
    .rf_fp_we_o      (rf_fp_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .fflags_we_i     (ff_we),
    .fflags_wdata_i  (ff_wdata),
    .fflags_o        (fflags),
    .query_addr_i    (q_addr),
    .query_fp_i      (q_fp),
    .query_hit_o     (q_hit),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check outputs against the scoreboard, advance model.
  task automatic cyc(input logic v, input logic [31:0] d,
                     input logic [4:0] a, input logic di,
                     input logic [4:0] st, input logic ir,
                     input logic fl, input logic fwe,
                     input logic [4:0] fwd);
    fp_wb_entry_t h;
    fp_wb_entry_t e;
    logic         ep;
    logic         epush;
    logic         ehit;
    logic [4:0]   nff;
    fpu_valid = v;  fpu_result = d;  fpu_waddr = a;
    fpu_dst_int = di;  fpu_status = st;
    int_wb_req = ir;  flush = fl;  ff_we = fwe;  ff_wdata = fwd;
    #1;
    ep    = (sb.size() > 0) && !ir && !fl;
    epush = v && (sb.size() < Depth) && !fl;
    chk("ready", fpu_ready, sb.size() < Depth);
    chk("busy", busy, sb.size() != 0);
    chk("fflags", fflags, mff);
    ehit = 1'b0;
    foreach (sb[i]) begin
      if (sb[i].waddr == q_addr && sb[i].dst_int == !q_fp) ehit = 1'b1;
    end
    if (!q_fp && q_addr == 5'd0) ehit = 1'b0;
    chk("query_hit", q_hit, ehit);
    h = '0;
    if (ep) h = sb[0];
    chk("rf_int_we", rf_int_we, ep && h.dst_int && h.waddr != 5'd0);
    chk("rf_fp_we", rf_fp_we, ep && !h.dst_int);
    chk("rf_waddr", rf_waddr, ep ? h.waddr : 5'd0);
    chk("rf_wdata", rf_wdata, ep ? h.data : 32'd0);
    nff = (fwe ? fwd : mff) | (ep ? 5'(h.status) : 5'd0);
    e.data = d;  e.waddr = a;  e.dst_int = di;  e.status = status_t'(st);
    if (fl) sb.delete();
    else begin
      if (ep) void'(sb.pop_front());
      if (epush) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    mff = nff;
  endtask

  task automatic idle(input logic ir);
    cyc(1'b0, 32'd0, 5'd0, 1'b0, 5'd0, ir, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    mff = '0;
    rst_n = 1'b0;
    fpu_valid = 0;  fpu_result = 0;  fpu_status = 0;
    fpu_waddr = 0;  fpu_dst_int = 0;  int_wb_req = 0;
    flush = 0;  ff_we = 0;  ff_wdata = 0;
    q_addr = 0;  q_fp = 0;
    #1;
    chk("rst_ready", fpu_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fflags", fflags, 5'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1'b0);

    // single op
    cyc(1, 32'h3F800000, 5'd5, 0, 5'b00001, 0, 0, 0, 5'd0);
    idle(1'b0);
    chk("single_fflags", fflags, 5'b00001);

    // back-pressure, third result held at the FPU
    cyc(1, 32'h11111111, 5'd1, 0, 5'd0, 1, 0, 0, 5'd0);
    cyc(1, 32'h22222222, 5'd2, 1, 5'd0, 1, 0, 0, 5'd0);
    chk("bp_ready_low", fpu_ready, 1'b0);
    cyc(1, 32'h33333333, 5'd3, 0, 5'd0, 1, 0, 0, 5'd0);
    cyc(1, 32'h33333333, 5'd3, 0, 5'd0, 0, 0, 0, 5'd0);
    cyc(0, 32'h0, 5'd0, 0, 5'd0, 0, 0, 0, 5'd0);
    idle(1'b0);
    idle(1'b0);

    // sustained throughput
    for (int i = 0; i < 4; i++)
      cyc(1, 32'hA0 + i, 5'(8 + i), i[0], 5'd0, 0, 0, 0, 5'd0);
    idle(1'b0);

    // CSR write concurrent with pop
    cyc(0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b10000);
    chk("csr_set", fflags, 5'b10000);
    cyc(1, 32'h7F800000, 5'd4, 0, 5'b00100, 0, 0, 0, 5'd0);
    cyc(0, 0, 0, 0, 5'd0, 0, 0, 1, 5'b00000);
    chk("csr_pop", fflags, 5'b00100);

    // flush with two buffered and one incoming
    cyc(1, 32'h1, 5'd6, 0, 5'b01000, 1, 0, 0, 5'd0);
    cyc(1, 32'h2, 5'd7, 0, 5'b00010, 1, 0, 0, 5'd0);
    cyc(1, 32'h3, 5'd9, 0, 5'b00001, 0, 1, 0, 5'd0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_fflags", fflags, 5'b00100);
    idle(1'b0);

    // query and x0 integer destination
    q_addr = 5'd7;  q_fp = 1'b0;
    cyc(1, 32'hBEEF, 5'd7, 1, 5'd0, 1, 0, 0, 5'd0);
    cyc(1, 32'hCAFE, 5'd0, 1, 5'd0, 1, 0, 0, 5'd0);
    chk("q_int_hit", q_hit, 1'b1);
    q_fp = 1'b1;
    idle(1'b1);
    q_addr = 5'd0;  q_fp = 1'b0;
    idle(1'b1);
    q_addr = 5'd7;
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // async reset mid-drain
    cyc(1, 32'h55, 5'd12, 0, 5'b00010, 1, 0, 0, 5'd0);
    cyc(1, 32'h66, 5'd13, 1, 5'd0, 1, 0, 0, 5'd0);
    cyc(0, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0);
    int_wb_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", fpu_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_fflags", fflags, 5'd0);
    chk("arst_fp_we", rf_fp_we, 1'b0);
    chk("arst_int_we", rf_int_we, 1'b0);
    sb.delete();
    mff = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 32'h77, 5'd14, 0, 5'b00001, 0, 0, 0, 5'd0);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
